// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        HOLD
    } state_e;

    // Bit positions inside the 3-bit per-word error field
    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_BRK = 2;

    localparam int OSR_16 = 16;
    localparam int OSR_8  = 8;

    // 2-of-3 majority vote of the three mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same clock.
module uart_rx_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; when full with a pop, the write lands on the slot being freed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled majority-vote bit recovery,
// parity/framing/break detection and a receive FIFO with sticky overrun.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int MAX_DATA_W  = 9,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          baud_tick,
    input  logic                          osm_sel,
    input  logic [3:0]                    wls,
    input  logic                          pen,
    input  logic                          eps,
    input  logic                          stb,
    input  logic                          rx_i,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [MAX_DATA_W-1:0]         rd_data,
    output logic [2:0]                    rd_err,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          busy
);

    localparam int FW = MAX_DATA_W + 3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;
    logic                   rx_prev_q;

    state_e                 state_q, state_d;
    logic [3:0]             tick_q, tick_d;
    logic                   s0_q, s0_d;
    logic                   s1_q, s1_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [MAX_DATA_W-1:0]  data_q, data_d;
    logic                   par_q, par_d;
    logic                   zero_q, zero_d;
    logic                   perr_q, perr_d;
    logic                   frm_q, frm_d;
    logic                   brk_q, brk_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic [3:0]             osr_last;
    logic [3:0]             mid;
    logic [3:0]             nbits;
    logic                   dec;
    logic                   wrap;
    logic                   bit_v;
    logic                   stop_frm;
    logic                   push;
    logic [2:0]             push_err;
    logic                   drop;
    logic [FW-1:0]          head;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign osr_last = osm_sel ? 4'(OSR_8 - 1) : 4'(OSR_16 - 1);
    assign mid      = osm_sel ? 4'(OSR_8 / 2) : 4'(OSR_16 / 2);
    assign dec      = baud_tick && (tick_q == mid + 4'd1);
    assign wrap     = baud_tick && (tick_q == osr_last);
    assign bit_v    = maj3(s0_q, s1_q, rx_s);

    // Synchroniser shift chain, rx_i enters at bit 0
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    // Data length, clamped to the widest supported word
    always_comb begin
        if (wls > 4'(MAX_DATA_W - 5)) nbits = 4'(MAX_DATA_W);
        else                          nbits = wls + 4'd5;
    end

    // Receive FSM next-state: bit actions at the decision tick, bit advance at wrap
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        zero_d    = zero_q;
        perr_d    = perr_q;
        frm_d     = frm_q;
        brk_d     = brk_q;
        stop_frm  = 1'b0;
        push      = 1'b0;
        push_err  = '0;

        if (baud_tick) begin
            tick_d = (tick_q == osr_last) ? '0 : tick_q + 4'd1;
            if (tick_q == mid - 4'd1) s0_d = rx_s;
            if (tick_q == mid)        s1_d = rx_s;
        end

        unique case (state_q)
            IDLE: begin
                if (en && rx_prev_q && !rx_s) begin
                    tick_d    = '0;
                    bit_cnt_d = '0;
                    data_d    = '0;
                    par_d     = 1'b0;
                    zero_d    = 1'b1;
                    perr_d    = 1'b0;
                    frm_d     = 1'b0;
                    brk_d     = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (dec && bit_v) state_d = IDLE;
                else if (wrap)    state_d = DATA;
            end
            DATA: begin
                if (dec) begin
                    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
                        if (bit_cnt_q == 4'(i)) data_d[i] = bit_v;
                    end
                    par_d     = par_q ^ bit_v;
                    zero_d    = zero_q & ~bit_v;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (wrap && (bit_cnt_q == nbits)) state_d = pen ? PARITY : STOP1;
            end
            PARITY: begin
                if (dec) begin
                    perr_d = par_q ^ bit_v ^ ~eps;
                    zero_d = zero_q & ~bit_v;
                end
                if (wrap) state_d = STOP1;
            end
            STOP1: begin
                if (dec) begin
                    frm_d = ~bit_v;
                    brk_d = zero_q & ~bit_v;
                    if (!stb) begin
                        push               = 1'b1;
                        push_err[ERR_BRK]  = zero_q & ~bit_v;
                        push_err[ERR_FRM]  = ~bit_v;
                        push_err[ERR_PAR]  = perr_q;
                        state_d            = bit_v ? IDLE : HOLD;
                    end
                end
                if (wrap && stb) state_d = STOP2;
            end
            STOP2: begin
                if (dec) begin
                    stop_frm           = frm_q | ~bit_v;
                    push               = 1'b1;
                    push_err[ERR_BRK]  = brk_q;
                    push_err[ERR_FRM]  = stop_frm;
                    push_err[ERR_PAR]  = perr_q;
                    state_d            = stop_frm ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d = IDLE;
            push    = 1'b0;
        end
    end

    // Registered busy flag and sticky overrun; a drop outranks ovr_clr
    always_comb begin
        busy_d    = (state_d != IDLE);
        overrun_d = drop | (overrun_q & ~ovr_clr);
    end

    assign drop = push && full && !rd_en;

    // All receiver state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            tick_q    <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            zero_q    <= 1'b0;
            perr_q    <= 1'b0;
            frm_q     <= 1'b0;
            brk_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            tick_q    <= tick_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            zero_q    <= zero_d;
            perr_q    <= perr_d;
            frm_q     <= frm_d;
            brk_q     <= brk_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({push_err, data_d}),
        .pop   (rd_en),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign rd_data = head[MAX_DATA_W-1:0];
    assign rd_err  = head[FW-1:MAX_DATA_W];
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule
